// File: rtl/alu_iq_collapse.sv
// Age-ordered collapsing issue queue for the ALU pipe.
// Sits between rename/dispatch and ALU register read. Valid entries are kept contiguous from
// slot 0 (oldest). Each cycle the oldest ready entry moves into a registered select stage, and
// the younger entries shift down to close the gap.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               clears the queue and the issue register valid
//   disp_*              up to DISP_W dispatched instructions per cycle, lane 0 oldest, packed
//   wake_vld/wake_tag   WB_W result tag broadcasts that mark matching sources ready
//   iss_pause           downstream stall; holds the issue register and blocks selection
//   disp_stall          whole dispatch group rejected for lack of room (combinational)
//   free_cnt            DEPTH minus registered occupancy
//   iss_*               issue register contents
module alu_iq_collapse #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DISP_W = 4,
  parameter int unsigned WB_W   = 3,
  parameter int unsigned PR_W   = 7,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned IMM_W  = 20,
  parameter int unsigned ROB_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DISP_W-1:0]            disp_vld,
  input  logic [DISP_W-1:0]            disp_src1_en,
  input  logic [DISP_W-1:0]            disp_src2_en,
  input  logic [DISP_W-1:0]            disp_src1_rdy,
  input  logic [DISP_W-1:0]            disp_src2_rdy,
  input  logic [DISP_W*PR_W-1:0]       disp_dest,
  input  logic [DISP_W*PR_W-1:0]       disp_src1,
  input  logic [DISP_W*PR_W-1:0]       disp_src2,
  input  logic [DISP_W*OP_W-1:0]       disp_op,
  input  logic [DISP_W*IMM_W-1:0]      disp_imm,
  input  logic [DISP_W*ROB_W-1:0]      disp_rob_id,
  input  logic [WB_W-1:0]              wake_vld,
  input  logic [WB_W*PR_W-1:0]         wake_tag,
  input  logic                         iss_pause,
  output logic                         disp_stall,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
  output logic                         iss_vld,
  output logic [OP_W-1:0]              iss_op,
  output logic [IMM_W-1:0]             iss_imm,
  output logic [PR_W-1:0]              iss_dest,
  output logic [PR_W-1:0]              iss_src1,
  output logic [PR_W-1:0]              iss_src2,
  output logic [ROB_W-1:0]             iss_rob_id
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);
  // One extra bit so room = free + 1 cannot wrap.
  localparam int unsigned RW = CW + 1;

  typedef struct packed {
    logic             s1_en;
    logic             s1_rdy;
    logic             s2_en;
    logic             s2_rdy;
    logic [PR_W-1:0]  dest;
    logic [PR_W-1:0]  src1;
    logic [PR_W-1:0]  src2;
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    gnt;
  logic             any_rdy;
  logic             iss;
  logic [CW-1:0]    need;
  logic [CW-1:0]    base;
  logic [RW-1:0]    room;
  logic             disp_we;
  logic [CW-1:0]    pos;
  entry_t           lane;

  // Readiness and oldest-first select.
  always_comb begin
    rdy     = '0;
    gnt     = '0;
    any_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = (CW'(i) < cnt_q) && (!ent_q[i].s1_en || ent_q[i].s1_rdy) &&
               (!ent_q[i].s2_en || ent_q[i].s2_rdy);
    end
    // Descending scan so the lowest ready index is the last one written.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        gnt     = IW'(i);
        any_rdy = 1'b1;
      end
    end
    iss = any_rdy && !iss_pause && !flush;
  end

  // Dispatch admission; all-or-nothing per group.
  always_comb begin
    need = '0;
    for (int k = 0; k < DISP_W; k++) begin
      need = need + CW'(disp_vld[k]);
    end
    room       = RW'(DEPTH) - RW'(cnt_q) + RW'(iss);
    disp_stall = RW'(need) > room;
    disp_we    = !disp_stall && !flush && (need != '0);
    // First free slot after this cycle's collapse.
    base       = cnt_q - CW'(iss);
    cnt_d      = flush ? '0 : (disp_we ? base + need : base);
  end

  // Next-state entries: collapse, then append dispatch, then apply wakeups.
  always_comb begin
    ent_d = ent_q;
    pos   = base;
    lane  = '0;
    if (iss) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(gnt)) ent_d[i] = ent_q[i+1];
      end
    end
    if (disp_we) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_vld[k]) begin
          lane.s1_en  = disp_src1_en[k];
          lane.s1_rdy = disp_src1_rdy[k];
          lane.s2_en  = disp_src2_en[k];
          lane.s2_rdy = disp_src2_rdy[k];
          lane.dest   = disp_dest[k*PR_W +: PR_W];
          lane.src1   = disp_src1[k*PR_W +: PR_W];
          lane.src2   = disp_src2[k*PR_W +: PR_W];
          lane.op     = disp_op[k*OP_W +: OP_W];
          lane.imm    = disp_imm[k*IMM_W +: IMM_W];
          lane.rob_id = disp_rob_id[k*ROB_W +: ROB_W];
          if (pos < CW'(DEPTH)) ent_d[IW'(pos)] = lane;
          pos = pos + CW'(1);
        end
      end
    end
    // Applied after the dispatch write so same-cycle broadcasts are not lost.
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < WB_W; j++) begin
        if (wake_vld[j]) begin
          if (ent_d[i].src1 == wake_tag[j*PR_W +: PR_W]) ent_d[i].s1_rdy = 1'b1;
          if (ent_d[i].src2 == wake_tag[j*PR_W +: PR_W]) ent_d[i].s2_rdy = 1'b1;
        end
      end
    end
  end

  // Entry payload needs no reset: slots at or above cnt_q are never selected.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld    <= 1'b0;
      iss_op     <= '0;
      iss_imm    <= '0;
      iss_dest   <= '0;
      iss_src1   <= '0;
      iss_src2   <= '0;
      iss_rob_id <= '0;
    end else if (flush) begin
      iss_vld <= 1'b0;
    end else if (!iss_pause) begin
      iss_vld <= iss;
      if (iss) begin
        iss_op     <= ent_q[gnt].op;
        iss_imm    <= ent_q[gnt].imm;
        iss_dest   <= ent_q[gnt].dest;
        iss_src1   <= ent_q[gnt].src1;
        iss_src2   <= ent_q[gnt].src2;
        iss_rob_id <= ent_q[gnt].rob_id;
      end
    end
  end

  assign free_cnt = CW'(DEPTH) - cnt_q;

endmodule

// File: tb/tb_alu_iq_collapse.sv
// Directed, table-driven bench for alu_iq_collapse with default parameters.
module tb_alu_iq_collapse;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  disp_vld, disp_src1_en, disp_src2_en, disp_src1_rdy, disp_src2_rdy;
  logic [27:0] disp_dest, disp_src1, disp_src2;
  logic [19:0] disp_op;
  logic [79:0] disp_imm;
  logic [23:0] disp_rob_id;
  logic [2:0]  wake_vld;
  logic [20:0] wake_tag;
  logic        iss_pause;
  logic        disp_stall;
  logic [3:0]  free_cnt;
  logic        iss_vld;
  logic [4:0]  iss_op;
  logic [19:0] iss_imm;
  logic [6:0]  iss_dest, iss_src1, iss_src2;
  logic [5:0]  iss_rob_id;

  int n_vec = 0;
  int n_bad = 0;

  alu_iq_collapse dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_vld     (disp_vld),
    .disp_src1_en (disp_src1_en),
    .disp_src2_en (disp_src2_en),
    .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_rdy(disp_src2_rdy),
    .disp_dest    (disp_dest),
    .disp_src1    (disp_src1),
    .disp_src2    (disp_src2),
    .disp_op      (disp_op),
    .disp_imm     (disp_imm),
    .disp_rob_id  (disp_rob_id),
    .wake_vld     (wake_vld),
    .wake_tag     (wake_tag),
    .iss_pause    (iss_pause),
    .disp_stall   (disp_stall),
    .free_cnt     (free_cnt),
    .iss_vld      (iss_vld),
    .iss_op       (iss_op),
    .iss_imm      (iss_imm),
    .iss_dest     (iss_dest),
    .iss_src1     (iss_src1),
    .iss_src2     (iss_src2),
    .iss_rob_id   (iss_rob_id)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs, then stall expected before the edge and outputs after it.
  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
    int         tag;
    int         rob;
    logic       wk;
    int         wtag;
    logic       pause;
    logic       fl;
    logic       e_stall;
    logic       e_ivld;
    int         e_rob;
    int         e_src1;
    int         e_free;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lane k gets src1 = tag+k, rob = rob+k; src1 used, src2 unused.
  task automatic drive_lanes(input logic [3:0] vld, input logic [3:0] rdy, input int tag,
                             input int rob);
    disp_vld      = vld;
    disp_src1_en  = 4'hF;
    disp_src1_rdy = rdy;
    disp_src2_en  = 4'h0;
    disp_src2_rdy = 4'h0;
    disp_src2     = '0;
    for (int k = 0; k < 4; k++) begin
      disp_src1[k*7 +: 7]   = 7'(tag + k);
      disp_dest[k*7 +: 7]   = 7'(100 + k);
      disp_rob_id[k*6 +: 6] = 6'(rob + k);
      disp_op[k*5 +: 5]     = 5'(k);
      disp_imm[k*20 +: 20]  = 20'(k * 1000);
    end
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'hF,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0, 4};
    tbl[1]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1,  0,  0, 5};
    tbl[2]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1,  1,  1, 6};
    tbl[3]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1,  2,  2, 7};
    tbl[4]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1,  3,  3, 8};
    tbl[5]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0, 8};
    tbl[6]  = '{4'hF, 4'h0, 10,  8, 0,  0, 0, 0, 0, 0,  0,  0, 4};
    tbl[7]  = '{4'hF, 4'h0, 14, 12, 0,  0, 0, 0, 0, 0,  0,  0, 0};
    tbl[8]  = '{4'h0, 4'h0,  0,  0, 1, 13, 0, 0, 0, 0,  0,  0, 0};
    tbl[9]  = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1, 11, 13, 1};
    tbl[10] = '{4'h1, 4'h0, 30, 16, 0,  0, 0, 0, 0, 0,  0,  0, 0};
    tbl[11] = '{4'h0, 4'h0,  0,  0, 1, 10, 0, 0, 0, 0,  0,  0, 0};
    tbl[12] = '{4'h1, 4'h0, 31, 17, 0,  0, 0, 0, 0, 1,  8, 10, 0};
    tbl[13] = '{4'h3, 4'h0, 40, 20, 1, 11, 0, 0, 1, 0,  0,  0, 0};
    tbl[14] = '{4'h3, 4'h0, 40, 20, 0,  0, 0, 0, 1, 1,  9, 11, 1};
    tbl[15] = '{4'h0, 4'h0,  0,  0, 1, 14, 1, 0, 0, 1,  9, 11, 1};
    tbl[16] = '{4'h0, 4'h0,  0,  0, 0,  0, 1, 0, 0, 1,  9, 11, 1};
    tbl[17] = '{4'h0, 4'h0,  0,  0, 0,  0, 1, 0, 0, 1,  9, 11, 1};
    tbl[18] = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1, 12, 14, 2};
    tbl[19] = '{4'h0, 4'h0,  0,  0, 1, 12, 0, 0, 0, 0,  0,  0, 2};
    tbl[20] = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1, 10, 12, 3};
    tbl[21] = '{4'h1, 4'h1, 41, 40, 0,  0, 1, 1, 0, 0,  0,  0, 8};
    tbl[22] = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0, 8};
    tbl[23] = '{4'hD, 4'h0, 18, 24, 1, 20, 0, 0, 0, 0,  0,  0, 5};
    tbl[24] = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 1, 26, 20, 6};
    tbl[25] = '{4'h0, 4'h0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0, 6};

    rst       = 1'b1;
    flush     = 1'b0;
    iss_pause = 1'b0;
    wake_vld  = '0;
    wake_tag  = '0;
    drive_lanes(4'h0, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset free_cnt", int'(free_cnt), 8);
    check("reset iss_vld", int'(iss_vld), 0);
    check("reset iss_rob_id", int'(iss_rob_id), 0);
    check("reset stall", int'(disp_stall), 0);

    for (int i = 0; i < 26; i++) begin
      drive_lanes(tbl[i].vld, tbl[i].rdy, tbl[i].tag, tbl[i].rob);
      wake_vld  = {2'b00, tbl[i].wk};
      wake_tag  = {14'd0, 7'(tbl[i].wtag)};
      iss_pause = tbl[i].pause;
      flush     = tbl[i].fl;
      #1;
      check($sformatf("v%0d disp_stall", i), int'(disp_stall), int'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d iss_vld", i), int'(iss_vld), int'(tbl[i].e_ivld));
      check($sformatf("v%0d free_cnt", i), int'(free_cnt), tbl[i].e_free);
      if (tbl[i].e_ivld) begin
        check($sformatf("v%0d iss_rob_id", i), int'(iss_rob_id), tbl[i].e_rob);
        check($sformatf("v%0d iss_src1", i), int'(iss_src1), tbl[i].e_src1);
      end
    end

    // Queue holds rob24 (src1 18) and rob27 (src1 21), both waiting.
    // Four entries waiting only on src2 tag 60.
    drive_lanes(4'hF, 4'hF, 50, 30);
    disp_src2_en = 4'hF;
    for (int k = 0; k < 4; k++) disp_src2[k*7 +: 7] = 7'd60;
    wake_vld  = '0;
    iss_pause = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    check("h1 free_cnt", int'(free_cnt), 2);
    // Seventh entry, not ready.
    drive_lanes(4'h1, 4'h0, 70, 34);
    @(posedge clk);
    #1;
    check("h2 free_cnt", int'(free_cnt), 1);
    // DEPTH-1 occupied, no issue possible: two lanes stall, zero lanes do not.
    drive_lanes(4'h3, 4'h0, 80, 40);
    #1;
    check("h3 stall need2", int'(disp_stall), 1);
    disp_vld = 4'h0;
    #1;
    check("h3 stall need0", int'(disp_stall), 0);
    // Two ports at once: port 0 wakes rob27's src1, port 2 wakes the src2 group.
    wake_vld = 3'b101;
    wake_tag = {7'd60, 7'd0, 7'd21};
    @(posedge clk);
    #1;
    check("h3 iss_vld", int'(iss_vld), 0);
    check("h3 free_cnt", int'(free_cnt), 1);
    wake_vld = '0;
    @(posedge clk);
    #1;
    check("h4 iss_vld", int'(iss_vld), 1);
    check("h4 iss_rob_id", int'(iss_rob_id), 27);
    check("h4 free_cnt", int'(free_cnt), 2);
    @(posedge clk);
    #1;
    check("h5 iss_rob_id", int'(iss_rob_id), 30);
    check("h5 iss_src2", int'(iss_src2), 60);
    check("h5 free_cnt", int'(free_cnt), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_iq_collapse.md
Name: alu_iq_collapse

Overview:
- Parametrised, age-ordered collapsing issue queue for an ALU pipe, sitting between rename/dispatch and the ALU register-read stage.
- Accepts up to DISP_W instructions per cycle and tracks operand readiness via WB_W wakeup tag broadcasts.
- Each cycle it issues the oldest ready entry into a registered select stage, with back-pressure on both sides and flush support.

Parameters:
DEPTH, 8, number of queue entries (>=4)
DISP_W, 4, dispatch lanes per cycle (1..DEPTH)
WB_W, 3, wakeup broadcast ports
PR_W, 7, physical register tag width
OP_W, 5, opcode width
IMM_W, 20, immediate width
ROB_W, 6, ROB index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush, clears queue
disp_vld  in  DISP_W  per-lane dispatch valid, lane 0 oldest
disp_src1_en / disp_src2_en  in  DISP_W  operand uses a register
disp_src1_rdy / disp_src2_rdy  in  DISP_W  operand ready at rename
disp_dest / disp_src1 / disp_src2  in  DISP_W*PR_W  packed tags, lane k at [k*PR_W +: PR_W]
disp_op  in  DISP_W*OP_W  packed opcodes
disp_imm  in  DISP_W*IMM_W  packed immediates
disp_rob_id  in  DISP_W*ROB_W  packed ROB IDs
wake_vld  in  WB_W  wakeup broadcast valid
wake_tag  in  WB_W*PR_W  packed broadcast dest tags
iss_pause  in  1  downstream stall, hold issue register
disp_stall  out  1  insufficient room, whole dispatch group rejected
free_cnt  out  clog2(DEPTH+1)  free entries (DEPTH - occupancy), registered-state based
iss_vld  out  1  issue register valid
iss_op / iss_imm / iss_dest / iss_src1 / iss_src2 / iss_rob_id  out  OP_W/IMM_W/PR_W/PR_W/PR_W/ROB_W  issued instruction fields

Behaviour:
- Storage: entries 0..DEPTH-1. Valid entries are always contiguous from index 0; index 0 is oldest. Occupancy register cnt holds 0..DEPTH.
- Ready: rdy[i] = vld[i] & (!s1_en[i] | s1_rdy[i]) & (!s2_en[i] | s2_rdy[i]).
- Select: grant = lowest-index rdy entry. It is only taken when !iss_pause & !flush (issue event "iss").
- Issue register:
  - !iss_pause: iss_vld <= iss; on iss, fields <= granted entry.
  - iss_pause: all iss_* hold; no entry is removed.
- Collapse: on iss of entry g, entries g+1..cnt-1 shift down one slot in the same edge and cnt decrements. Field contents and rdy bits move with the entry.
- Wakeup: at each edge, any src of a valid entry, or of an entry being written, whose tag equals wake_tag[j] with wake_vld[j] gets its rdy set. This covers same-cycle dispatch bypass. rdy bits never clear except on entry reuse.
- Dispatch:
  - need = popcount(disp_vld); room = (DEPTH - cnt) + iss.
  - disp_stall = (need > room), combinational.
  - If !disp_stall & !flush, valid lanes are packed in lane order, skipping invalid lanes, into slots starting at cnt - iss. Then cnt <= cnt - iss + need.
  - If disp_stall, nothing is written (all-or-nothing).
- Latency: an instruction dispatched ready at edge N is selectable in cycle N+1 and appears on iss_* after edge N+1.
- Flush (dominant over dispatch and issue): at the edge, all vld <= 0, cnt <= 0, iss_vld <= 0 (even if iss_pause). disp_stall is still computed from the current state but ignored.
- Reset: same as flush; additionally all iss_* fields <= 0. free_cnt = DEPTH after reset. Reset wins over everything.
- Boundaries:
  - Full queue with an issue in the same cycle accepts one instruction.
  - need=0 never stalls.
  - DEPTH-1 entries plus need=2 with no issue stalls.

Test Plan:
- Reset, then dispatch 4 ready ops (ROB 0..3) -> free_cnt 8->4; iss_rob_id 0,1,2,3 on consecutive cycles with iss_vld=1; queue empty after 4 issues.
- Fill 8 unready entries (src1 tags 10..17), then wake_tag=13 -> next cycle iss_src1=13, entries 4..7 collapse to 3..6, free_cnt=1.
- Queue holds 8 unready entries; wake one; dispatch need=1 in the grant cycle -> disp_stall=0, new entry lands in slot 7; need=2 -> disp_stall=1, nothing written.
- Dispatch lanes {1,0,1,1} with lane2 src1=20 unready and wake_tag=20 in the same cycle -> 3 entries written contiguously; the lane2 entry issues on the following cycle.
- iss_pause held 3 cycles with ready entries -> iss_* frozen, cnt unchanged; on release the oldest ready entry issues.
- Flush with 5 entries and iss_pause=1 -> next cycle iss_vld=0, free_cnt=8; a dispatch presented in the flush cycle is dropped.
